// File: rtl/usb_bit_stuffer_if.sv
// usb_bit_stuffer_if: groups the upstream serial handshake and the framed
// line-side output of the USB bit stuffer.
//   master: the side that drives the upstream bitstream (serializer/bench)
//   slave : the bit stuffer itself
`timescale 1ns/1ps

interface usb_bit_stuffer_if;
  logic       pkt_start;
  logic       s_in;
  logic       s_valid;
  logic       s_last;
  logic       s_stall;
  logic       out_bit;
  logic       out_valid;
  logic       out_last;
  logic       pkt_done;
  logic [3:0] run_cnt;

  modport master (
    output pkt_start, s_in, s_valid, s_last,
    input  s_stall, out_bit, out_valid, out_last, pkt_done, run_cnt
  );

  modport slave (
    input  pkt_start, s_in, s_valid, s_last,
    output s_stall, out_bit, out_valid, out_last, pkt_done, run_cnt
  );
endinterface : usb_bit_stuffer_if

// File: rtl/usb_bit_stuffer.sv
// usb_bit_stuffer: inserts a 0 after every MAX_RUN consecutive 1s of the
// outgoing packet bitstream (PID, payload, CRC16), stalls the upstream for
// one cycle per inserted bit and frames the stream with out_last/pkt_done.
//
// Optional build macro: USB_BITSTUFF_NRZI_EN
//   defined     : out_bit carries the NRZI line level (J=1 after reset and
//                 at every pkt_start; data 0 toggles, data 1 holds).
//   not defined : out_bit carries the raw stuffed bit.
//
// MAX_RUN must lie in 2..15 so the run counter fits in 4 bits.
`timescale 1ns/1ps

module usb_bit_stuffer #(
  parameter int unsigned MAX_RUN = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  usb_bit_stuffer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    STUFF  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Run count value at which one more accepted 1 completes a full run.
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_RUN - 1);

  state_t     state_q,     state_d;
  logic [3:0] run_cnt_q,   run_cnt_d;
  logic       pending_q,   pending_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q,  out_last_d;
  logic       pkt_done_q,  pkt_done_d;

  // Bit handed to the line this cycle (data bit or stuff 0).
  logic       emit;
  logic       emit_bit;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the reset branch is asynchronous via the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output decode.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    pending_d   = pending_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    pkt_done_d  = 1'b0;
    emit        = 1'b0;
    emit_bit    = 1'b0;

    case (state_q)
      IDLE: begin
        // Upstream data is ignored until a packet is opened.
        if (bus.pkt_start) begin
          state_d   = STREAM;
          run_cnt_d = 4'd0;
        end
      end

      STREAM: begin
        // Without s_valid the run count is held so a run spans gaps.
        if (bus.s_valid) begin
          emit        = 1'b1;
          emit_bit    = bus.s_in;
          out_valid_d = 1'b1;
          run_cnt_d   = bus.s_in ? run_cnt_q + 4'd1 : 4'd0;
          if (bus.s_in && (run_cnt_q == RUN_LIMIT)) begin
            // Run complete: a stuff 0 follows even if this was the last bit,
            // in which case the stuff bit carries out_last instead.
            state_d   = STUFF;
            pending_d = bus.s_last;
          end else if (bus.s_last) begin
            out_last_d = 1'b1;
            state_d    = DONE;
          end
        end
      end

      STUFF: begin
        // Upstream is stalled and holds its bit; emit the stuff 0.
        emit        = 1'b1;
        emit_bit    = 1'b0;
        out_valid_d = 1'b1;
        run_cnt_d   = 4'd0;
        if (pending_q) begin
          out_last_d = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = STREAM;
        end
      end

      DONE: begin
        pkt_done_d = 1'b1;
        pending_d  = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered framing outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q   <= 4'd0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      run_cnt_q   <= run_cnt_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

`ifdef USB_BITSTUFF_NRZI_EN
  logic level_q, level_d;
  logic reload;

  // Line returns to J (1) whenever a new packet is opened.
  assign reload = (state_q == IDLE) && bus.pkt_start;

  // NRZI encode: data 0 toggles the line level, data 1 holds it.
  always_comb begin
    level_d = level_q;
    if (reload) begin
      level_d = 1'b1;
    end else if (emit) begin
      level_d = emit_bit ? level_q : ~level_q;
    end
  end

  // Line-level register; holds between bits, in IDLE and in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_d;
    end
  end

  assign bus.out_bit = level_q;
`else
  logic raw_q;

  // Raw stuffed bit; holds its value while nothing is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
    end else if (emit) begin
      raw_q <= emit_bit;
    end
  end

  assign bus.out_bit = raw_q;
`endif

  assign bus.s_stall   = (state_q == STUFF);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.run_cnt   = run_cnt_q;

endmodule : usb_bit_stuffer

// File: tb/tb_usb_bit_stuffer.sv
// tb_usb_bit_stuffer: scoreboard bench for usb_bit_stuffer. Each accepted
// upstream bit pushes its expected line output (plus any stuff 0) into a
// queue; a negedge monitor pops and compares every emitted bit.
`timescale 1ns/1ps

module tb_usb_bit_stuffer;

  localparam int MAX_RUN = 6;
`ifdef USB_BITSTUFF_NRZI_EN
  localparam logic RESET_BIT = 1'b1;
`else
  localparam logic RESET_BIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  usb_bit_stuffer_if bus ();

  usb_bit_stuffer #(.MAX_RUN(MAX_RUN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];

  int   checks       = 0;
  int   failures     = 0;
  int   stall_cycles = 0;
  int   done_cnt     = 0;
  logic prev_last    = 1'b0;
  int   tb_run       = 0;
  logic tb_level     = 1'b1;

  // Monitor: compares every emitted bit against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      exp_t e;
      if (bus.s_stall) stall_cycles++;
      if (bus.pkt_done) begin
        done_cnt++;
        checks++;
        if (prev_last !== 1'b1) begin
          failures++;
          $display("FAIL pkt_done_timing: pkt_done high, previous cycle out_last=%b, required 1", prev_last);
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: out_bit=%b out_last=%b emitted, required no output", bus.out_bit, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_bit, bus.out_last} !== {e.b, e.last}) begin
            failures++;
            $display("FAIL out_bit_last: got bit=%b last=%b, required bit=%b last=%b", bus.out_bit, bus.out_last, e.b, e.last);
          end
        end
      end
      prev_last = bus.out_valid && bus.out_last;
    end
  end

  // Expected line output for one emitted data bit.
  task automatic push_exp(input logic d, input logic last);
    exp_t e;
`ifdef USB_BITSTUFF_NRZI_EN
    if (!d) tb_level = ~tb_level;
    e.b = tb_level;
`else
    e.b = d;
`endif
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic start_pkt(input logic junk_valid, input logic junk_bit);
    bus.pkt_start = 1'b1;
    bus.s_valid   = junk_valid;
    bus.s_in      = junk_bit;
    bus.s_last    = 1'b0;
    @(negedge clk);
    bus.pkt_start = 1'b0;
    bus.s_valid   = 1'b0;
    tb_run        = 0;
    tb_level      = 1'b1;
  endtask

  // Offer one bit and hold it while the DUT stalls; expectations are pushed
  // just before the accepting edge.
  task automatic send_bit(input logic b, input logic last);
    bit accepted = 1'b0;
    bus.s_in    = b;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    for (int i = 0; i < 20; i++) begin
      if (!bus.s_stall) begin
        tb_run = b ? tb_run + 1 : 0;
        if (b && tb_run == MAX_RUN) begin
          push_exp(1'b1, 1'b0);
          push_exp(1'b0, last);
          tb_run = 0;
        end else begin
          push_exp(b, last);
        end
        @(negedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!accepted) begin
      failures++;
      $display("FAIL accept_timeout: bit %b not accepted within 20 cycles, required acceptance", b);
    end
  endtask

  task automatic gap(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Waits for pkt_done, then checks pulse count, queue drain and stall count.
  task automatic finish_pkt(input string name, input int done_before,
                            input int stall_before, input int exp_stalls);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done_cnt != done_before) break;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (done_cnt - done_before != 1) begin
      failures++;
      $display("FAIL %s_pkt_done: %0d pulses, required 1", name, done_cnt - done_before);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d expected bits not emitted, required 0", name, exp_q.size());
    end
    checks++;
    if (stall_cycles - stall_before != exp_stalls) begin
      failures++;
      $display("FAIL %s_stalls: %0d stall cycles, required %0d", name, stall_cycles - stall_before, exp_stalls);
    end
  endtask

  task automatic test_reset();
    bus.pkt_start = 1'b0;
    bus.s_in      = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_bit, bus.out_valid, bus.out_last, bus.pkt_done, bus.s_stall, bus.run_cnt}
        !== {RESET_BIT, 4'b0000, 4'd0}) begin
      failures++;
      $display("FAIL reset_values: bit=%b valid=%b last=%b done=%b stall=%b run=%0d, required bit=%b others 0",
               bus.out_bit, bus.out_valid, bus.out_last, bus.pkt_done, bus.s_stall, bus.run_cnt, RESET_BIT);
    end
    rst_n = 1'b1;
    // IDLE ignores s_valid without pkt_start; the monitor flags any output.
    bus.s_valid = 1'b1;
    bus.s_in    = 1'b1;
    repeat (3) @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_valid: out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    int s0 = stall_cycles;
    start_pkt(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    finish_pkt("basic", d0, s0, 0);
  endtask

  task automatic test_stuff();
    int d0 = done_cnt;
    int s0 = stall_cycles;
    start_pkt(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, i == 7);
    finish_pkt("stuff", d0, s0, 1);
  endtask

  task automatic test_last_on_run();
    int d0 = done_cnt;
    int s0 = stall_cycles;
    start_pkt(1'b0, 1'b0);
    for (int i = 0; i < MAX_RUN; i++) send_bit(1'b1, i == MAX_RUN - 1);
    finish_pkt("last_on_run", d0, s0, 1);
  endtask

  task automatic test_gap();
    int d0 = done_cnt;
    int s0 = stall_cycles;
    start_pkt(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.run_cnt !== 4'd5) begin
        failures++;
        $display("FAIL gap_run_cnt: run_cnt=%0d in gap cycle %0d, required 5", bus.run_cnt, i);
      end
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    finish_pkt("gap", d0, s0, 1);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int s0 = stall_cycles;
    start_pkt(1'b0, 1'b0);
    for (int i = 0; i < 13; i++) send_bit(1'b1, i == 12);
    finish_pkt("back_to_back", d0, s0, 2);
  endtask

  task automatic test_reset_in_stuff();
    int d0;
    int s0;
    start_pkt(1'b0, 1'b0);
    for (int i = 0; i < MAX_RUN; i++) send_bit(1'b1, 1'b0);
    checks++;
    if (bus.s_stall !== 1'b1) begin
      failures++;
      $display("FAIL stuff_entry: s_stall=%b after run, required 1", bus.s_stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_bit, bus.out_valid, bus.out_last, bus.pkt_done, bus.s_stall, bus.run_cnt}
        !== {RESET_BIT, 4'b0000, 4'd0}) begin
      failures++;
      $display("FAIL async_reset: bit=%b valid=%b last=%b done=%b stall=%b run=%0d, required bit=%b others 0",
               bus.out_bit, bus.out_valid, bus.out_last, bus.pkt_done, bus.s_stall, bus.run_cnt, RESET_BIT);
    end
    exp_q.delete();
    tb_run   = 0;
    tb_level = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    s0 = stall_cycles;
    // Aborted packet must not resume or complete without a fresh pkt_start.
    bus.s_valid = 1'b1;
    bus.s_in    = 1'b1;
    repeat (3) @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL abort_no_done: %0d pkt_done pulses after abort, required 0", done_cnt - d0);
    end
    start_pkt(1'b0, 1'b0);
    checks++;
    if (bus.run_cnt !== 4'd0) begin
      failures++;
      $display("FAIL restart_run_cnt: run_cnt=%0d, required 0", bus.run_cnt);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    finish_pkt("after_reset", d0, s0, 0);
  endtask

  task automatic test_nrzi();
    int   d0 = done_cnt;
    int   s0 = stall_cycles;
    logic data [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    start_pkt(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(data[i], i == 8);
    finish_pkt("nrzi", d0, s0, 1);
    d0 = done_cnt;
    s0 = stall_cycles;
    start_pkt(1'b0, 1'b0);
`ifdef USB_BITSTUFF_NRZI_EN
    checks++;
    if (bus.out_bit !== 1'b1) begin
      failures++;
      $display("FAIL nrzi_reload: level=%b after pkt_start, required 1", bus.out_bit);
    end
`endif
    send_bit(1'b1, 1'b1);
    finish_pkt("nrzi_next", d0, s0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_last_on_run();
    test_gap();
    test_back_to_back();
    test_reset_in_stuff();
    test_nrzi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_usb_bit_stuffer
